// File: rtl/display_driver_bcm_if.sv
// Bundle of the frame-memory fetch signals and HUB75 panel pins for display_driver_bcm.
//   row, column     fetch address (row/column being shifted)
//   pixel           {R8,G8,B8} per segment, returned one clk after the address
//   rgb             plane bit per segment, segment 0 in the LSBs
//   panel_row       panel address lines (row being displayed)
//   oe, lat, oclk   output enable (active high), latch strobe, shift clock
//   frame_complete  one-clk pulse once every pixel of the frame has been read
// master: the driver; slave: memory/panel side.
interface display_driver_bcm_if #(
  parameter int unsigned SEGMENTS = 2,
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLUMNS  = 64
);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        column;
  logic [24*SEGMENTS-1:0]  pixel;
  logic [3*SEGMENTS-1:0]   rgb;
  logic [ROW_W-1:0]        panel_row;
  logic                    oe;
  logic                    lat;
  logic                    oclk;
  logic                    frame_complete;

  modport master (
    output row, column, rgb, panel_row, oe, lat, oclk, frame_complete,
    input  pixel
  );

  modport slave (
    input  row, column, rgb, panel_row, oe, lat, oclk, frame_complete,
    output pixel
  );
endinterface

// File: rtl/display_driver_bcm.sv
// HUB75 panel driver using binary-coded modulation. Plane N+1 of a row is
// shifted while plane N is displayed with an on-time of LSB_CYCLES<<N clk.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   brightness   (only with DISPLAY_DRIVER_BRIGHTNESS_EN) scales on-time by (brightness+1)/256
//   bus          display_driver_bcm_if.master: fetch address/pixel and panel pins
// Optional feature macro: DISPLAY_DRIVER_BRIGHTNESS_EN.
module display_driver_bcm #(
  parameter int unsigned SEGMENTS   = 2,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLUMNS    = 64,
  parameter int unsigned BITWIDTH   = 8,
  parameter int unsigned LSB_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]            brightness,
`endif
  display_driver_bcm_if.master  bus
);
  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W      = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int unsigned PL_W       = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam int unsigned SHIFT_LAST = 2 * COLUMNS + 1;
  localparam int unsigned SC_W       = $clog2(SHIFT_LAST + 1);
  localparam int unsigned ON_MAX     = LSB_CYCLES << (BITWIDTH - 1);
  localparam int unsigned ON_W       = $clog2(ON_MAX + 1);
  localparam int unsigned BIT_BASE   = 8 - BITWIDTH;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BLANK = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t                 state_q, state_n;
  logic [SC_W-1:0]        sc_q, sc_n;
  logic [ROW_W-1:0]       row_q, row_n;
  logic [COL_W-1:0]       column_q, column_n;
  logic [PL_W-1:0]        plane_q, plane_n;
  logic [ROW_W-1:0]       panel_row_q, panel_row_n;
  logic [ON_W-1:0]        on_q, on_n;
  logic [3*SEGMENTS-1:0]  rgb_q, rgb_n;
  logic                   oe_q, oe_n;
  logic                   lat_q, lat_n;
  logic                   oclk_q, oclk_n;
  logic                   fc_q, fc_n;

  logic [2:0]             bit_idx_c;
  logic [3*SEGMENTS-1:0]  plane_rgb_c;
  logic [ON_W-1:0]        on_base_c;
  logic [ON_W-1:0]        on_load_c;

  // Channel bit carried by the plane currently being shifted
  assign bit_idx_c = 3'(BIT_BASE) + 3'(plane_q);

  // Select the plane bit of every colour channel of every segment
  always_comb begin
    logic [23:0] seg;
    logic [7:0]  r_ch, g_ch, b_ch;
    seg         = '0;
    r_ch        = '0;
    g_ch        = '0;
    b_ch        = '0;
    plane_rgb_c = '0;
    for (int s = 0; s < int'(SEGMENTS); s++) begin
      seg  = bus.pixel[24*s +: 24];
      r_ch = seg[23:16];
      g_ch = seg[15:8];
      b_ch = seg[7:0];
      plane_rgb_c[3*s +: 3] = {r_ch[bit_idx_c], g_ch[bit_idx_c], b_ch[bit_idx_c]};
    end
  end

  // On-time of the plane about to be latched
  assign on_base_c = ON_W'(LSB_CYCLES << plane_q);

`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
  localparam int unsigned PROD_W = ON_W + 9;
  logic [PROD_W-1:0] on_prod_c;
  assign on_prod_c = PROD_W'(on_base_c) * PROD_W'({1'b0, brightness} + 9'd1);
  assign on_load_c = ON_W'(on_prod_c >> 8);
`else
  assign on_load_c = on_base_c;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    sc_n        = sc_q;
    row_n       = row_q;
    plane_n     = plane_q;
    panel_row_n = panel_row_q;
    on_n        = (on_q != '0) ? on_q - ON_W'(1) : '0;
    oe_n        = (on_q > ON_W'(1));
    lat_n       = 1'b0;
    oclk_n      = 1'b0;
    fc_n        = 1'b0;
    rgb_n       = rgb_q;

    unique case (state_q)
      ST_SHIFT: begin
        // Pixel of column c is present on odd counts 2c+1; rgb changes with oclk low
        if (sc_q[0] && (sc_q < SC_W'(2 * COLUMNS))) begin
          rgb_n = plane_rgb_c;
        end
        oclk_n = !sc_q[0] && (sc_q >= SC_W'(2)) && (sc_q <= SC_W'(2 * COLUMNS));
        if (sc_q == SC_W'(SHIFT_LAST)) begin
          sc_n    = '0;
          fc_n    = (row_q == ROW_W'(ROWS - 1)) && (plane_q == PL_W'(BITWIDTH - 1));
          state_n = (on_q > ON_W'(1)) ? ST_WAIT : ST_BLANK;
        end else begin
          sc_n = sc_q + SC_W'(1);
        end
      end
      ST_WAIT: begin
        if (on_q <= ON_W'(1)) begin
          state_n = ST_BLANK;
        end
      end
      ST_BLANK: begin
        state_n = ST_LATCH;
        lat_n   = 1'b1;
      end
      ST_LATCH: begin
        // Shifted plane becomes the displayed one; advance to the next plane/row
        state_n     = ST_SHIFT;
        panel_row_n = row_q;
        on_n        = on_load_c;
        oe_n        = (on_load_c != '0);
        if (plane_q == PL_W'(BITWIDTH - 1)) begin
          plane_n = '0;
          row_n   = row_q + ROW_W'(1);
        end else begin
          plane_n = plane_q + PL_W'(1);
        end
      end
      default: state_n = ST_SHIFT;
    endcase
  end

  // Column follows the shift count; it wraps to 0 once the last column is issued
  assign column_n = COL_W'(sc_n >> 1);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SHIFT;
      sc_q        <= '0;
      row_q       <= '0;
      column_q    <= '0;
      plane_q     <= '0;
      panel_row_q <= '0;
      on_q        <= '0;
      rgb_q       <= '0;
      oe_q        <= 1'b0;
      lat_q       <= 1'b0;
      oclk_q      <= 1'b0;
      fc_q        <= 1'b0;
    end else begin
      state_q     <= state_n;
      sc_q        <= sc_n;
      row_q       <= row_n;
      column_q    <= column_n;
      plane_q     <= plane_n;
      panel_row_q <= panel_row_n;
      on_q        <= on_n;
      rgb_q       <= rgb_n;
      oe_q        <= oe_n;
      lat_q       <= lat_n;
      oclk_q      <= oclk_n;
      fc_q        <= fc_n;
    end
  end

  assign bus.row            = row_q;
  assign bus.column         = column_q;
  assign bus.rgb            = rgb_q;
  assign bus.panel_row      = panel_row_q;
  assign bus.oe             = oe_q;
  assign bus.lat            = lat_q;
  assign bus.oclk           = oclk_q;
  assign bus.frame_complete = fc_q;
endmodule

// File: tb/tb_display_driver_bcm.sv
// Directed bench for display_driver_bcm with a 1-clk registered frame memory.
module tb_display_driver_bcm;
  localparam int unsigned SEGMENTS   = 1;
  localparam int unsigned ROWS       = 8;
  localparam int unsigned COLUMNS    = 32;
  localparam int unsigned BITWIDTH   = 4;
  localparam int unsigned LSB_CYCLES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  display_driver_bcm_if #(.SEGMENTS(SEGMENTS), .ROWS(ROWS), .COLUMNS(COLUMNS)) bus ();

  logic [23:0] mem [ROWS][COLUMNS];
  always_ff @(posedge clk) bus.pixel <= mem[bus.row][bus.column];

`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif

  display_driver_bcm #(
    .SEGMENTS(SEGMENTS), .ROWS(ROWS), .COLUMNS(COLUMNS),
    .BITWIDTH(BITWIDTH), .LSB_CYCLES(LSB_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .bus(bus)
  );

  task automatic fill_mem(input logic [23:0] v);
    for (int r = 0; r < int'(ROWS); r++)
      for (int c = 0; c < int'(COLUMNS); c++)
        mem[r][c] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_lat(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.lat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int oclks, oe_seen;
    bit found;
    fill_mem(24'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.rgb, bus.oe, bus.lat, bus.oclk, bus.frame_complete} !== 7'b0) begin
      $display("FAIL reset_outputs: rgb/oe/lat/oclk/fc=%b expected 0",
               {bus.rgb, bus.oe, bus.lat, bus.oclk, bus.frame_complete});
    end else passed++;
    checks++;
    if ({bus.row, bus.column, bus.panel_row} !== 11'b0) begin
      $display("FAIL reset_address: row/column/panel_row=%b expected 0",
               {bus.row, bus.column, bus.panel_row});
    end else passed++;
    rst_n = 1'b1;
    oclks = 0; oe_seen = 0; found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.lat) begin
        found = 1'b1;
        break;
      end
      if (bus.oclk) oclks++;
      if (bus.oe) oe_seen++;
    end
    checks++;
    if (!found) $display("FAIL reset_first_lat: no lat within 200 clk");
    else passed++;
    checks++;
    if (oclks !== 32) $display("FAIL reset_oclk_count: got %0d expected 32", oclks);
    else passed++;
    checks++;
    if (oe_seen !== 0 || bus.oe !== 1'b0)
      $display("FAIL reset_oe_before_latch: oe high %0d clk, at lat %b, expected 0", oe_seen, bus.oe);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.oe !== 1'b1) $display("FAIL reset_oe_after_latch: oe=%b expected 1", bus.oe);
    else passed++;
  endtask

  task automatic test_plane_bits();
    int n, col, pl, r;
    logic [2:0] exp_rgb;
    for (int pat = 0; pat < 2; pat++) begin
      fill_mem(24'h0);
      if (pat == 0) begin
        mem[0][0] = 24'hff0000;
      end else begin
        mem[0][0]  = 24'h800000;
        mem[0][5]  = 24'h001001;
        mem[1][31] = 24'h0000f0;
      end
      do_reset();
      n = 0;
      for (int cyc = 0; cyc < 1500 && n < 256; cyc++) begin
        @(negedge clk);
        if (bus.oclk) begin
          col = n % 32;
          pl  = (n / 32) % 4;
          r   = n / 128;
          exp_rgb = 3'b000;
          if (pat == 0) begin
            if (r == 0 && col == 0) exp_rgb = 3'b100;
          end else begin
            if (r == 0 && col == 0 && pl == 3)      exp_rgb = 3'b100;
            else if (r == 0 && col == 5 && pl == 0) exp_rgb = 3'b010;
            else if (r == 1 && col == 31)           exp_rgb = 3'b001;
          end
          checks++;
          if (bus.rgb !== exp_rgb)
            $display("FAIL plane_bits pat%0d row%0d plane%0d col%0d: rgb=%b expected %b",
                     pat, r, pl, col, bus.rgb, exp_rgb);
          else passed++;
          n++;
        end
      end
      checks++;
      if (n !== 256) $display("FAIL plane_bits_pulses pat%0d: got %0d oclk expected 256", pat, n);
      else passed++;
    end
  endtask

  task automatic test_oe_width();
    int exp_w [4] = '{2, 4, 8, 16};
    int width, cyc;
    bit ok, got;
    logic [2:0] pr;
    fill_mem(24'h0);
    do_reset();
    wait_lat(200, ok);
    checks++;
    if (!ok) $display("FAIL oe_first_lat: no lat within 200 clk");
    else passed++;
    for (int k = 0; k < 4; k++) begin
      width = 0; cyc = 0; got = 1'b0; pr = '0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        cyc++;
        if (i == 0) pr = bus.panel_row;
        if (bus.lat) begin
          got = 1'b1;
          break;
        end
        if (bus.oe) width++;
      end
      checks++;
      if (width !== exp_w[k]) $display("FAIL oe_width plane%0d: got %0d clk expected %0d", k, width, exp_w[k]);
      else passed++;
      checks++;
      if (!got || cyc !== 68) $display("FAIL lat_interval plane%0d: got %0d clk (found=%0b) expected 68", k, cyc, got);
      else passed++;
      checks++;
      if (bus.oe !== 1'b0) $display("FAIL oe_at_lat plane%0d: oe=%b expected 0", k, bus.oe);
      else passed++;
      checks++;
      if (pr !== 3'd0) $display("FAIL oe_panel_row plane%0d: got %0d expected 0", k, pr);
      else passed++;
    end
  endtask

  task automatic test_frame_complete();
    int lats, fcs;
    bit pend;
    logic [2:0] exp_pr;
    logic prev_fc;
    fill_mem(24'h0);
    do_reset();
    lats = 0; fcs = 0; pend = 1'b0; prev_fc = 1'b0; exp_pr = '0;
    for (int i = 0; i < 6000 && lats < 65; i++) begin
      @(negedge clk);
      if (pend) begin
        checks++;
        if (bus.panel_row !== exp_pr)
          $display("FAIL panel_row after lat %0d: got %0d expected %0d", lats, bus.panel_row, exp_pr);
        else passed++;
        pend = 1'b0;
      end
      if (bus.frame_complete) begin
        fcs++;
        checks++;
        if ({bus.lat, bus.oclk} !== 2'b00)
          $display("FAIL fc_pins: lat/oclk=%b expected 00", {bus.lat, bus.oclk});
        else passed++;
        checks++;
        if (prev_fc !== 1'b0) $display("FAIL fc_width: pulse longer than 1 clk");
        else passed++;
        checks++;
        if (lats !== 32 * fcs - 1)
          $display("FAIL fc_position: pulse %0d after %0d lats expected %0d", fcs, lats, 32 * fcs - 1);
        else passed++;
      end
      prev_fc = bus.frame_complete;
      if (bus.lat) begin
        exp_pr = 3'((lats / 4) % 8);
        lats++;
        pend = 1'b1;
      end
    end
    checks++;
    if (lats !== 65) $display("FAIL fc_run_lats: got %0d expected 65", lats);
    else passed++;
    checks++;
    if (fcs !== 2) $display("FAIL fc_count: got %0d pulses expected 2", fcs);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit found;
    int oclks, oe_seen;
    fill_mem(24'hffffff);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.row == 3'd3 && bus.column == 5'd10) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) $display("FAIL mid_reach_row3: row 3 column 10 not reached");
    else passed++;
    checks++;
    if (bus.rgb !== 3'b111) $display("FAIL mid_rgb_before: rgb=%b expected 111", bus.rgb);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rgb, bus.oe, bus.lat, bus.oclk, bus.frame_complete} !== 7'b0)
      $display("FAIL mid_reset_outputs: rgb/oe/lat/oclk/fc=%b expected 0",
               {bus.rgb, bus.oe, bus.lat, bus.oclk, bus.frame_complete});
    else passed++;
    checks++;
    if ({bus.row, bus.column, bus.panel_row} !== 11'b0)
      $display("FAIL mid_reset_address: row/column/panel_row=%b expected 0",
               {bus.row, bus.column, bus.panel_row});
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    oclks = 0; oe_seen = 0; found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.lat) begin
        found = 1'b1;
        break;
      end
      if (bus.oclk) oclks++;
      if (bus.oe) oe_seen++;
    end
    checks++;
    if (!found || oclks !== 32) $display("FAIL mid_restart_shift: %0d oclk before lat (found=%0b) expected 32", oclks, found);
    else passed++;
    checks++;
    if (oe_seen !== 0) $display("FAIL mid_restart_oe: oe high %0d clk before first lat expected 0", oe_seen);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.panel_row !== 3'd0 || bus.oe !== 1'b1)
      $display("FAIL mid_restart_latch: panel_row=%0d oe=%b expected 0/1", bus.panel_row, bus.oe);
    else passed++;
  endtask

`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
  task automatic test_brightness();
    int exp_hi [4] = '{1, 2, 4, 8};
    int width, cyc, exp_w;
    bit ok, got;
    for (int b = 0; b < 2; b++) begin
      brightness = (b == 0) ? 8'd127 : 8'd0;
      fill_mem(24'h0);
      do_reset();
      wait_lat(200, ok);
      checks++;
      if (!ok) $display("FAIL bright_first_lat: no lat within 200 clk");
      else passed++;
      for (int k = 0; k < 4; k++) begin
        width = 0; cyc = 0; got = 1'b0;
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          cyc++;
          if (bus.lat) begin
            got = 1'b1;
            break;
          end
          if (bus.oe) width++;
        end
        exp_w = (b == 0) ? exp_hi[k] : 0;
        checks++;
        if (width !== exp_w)
          $display("FAIL bright_oe_width b=%0d plane%0d: got %0d clk expected %0d", brightness, k, width, exp_w);
        else passed++;
        checks++;
        if (!got || cyc !== 68)
          $display("FAIL bright_lat_interval b=%0d plane%0d: got %0d clk expected 68", brightness, k, cyc);
        else passed++;
      end
    end
    brightness = 8'd255;
  endtask
`endif

  initial begin
    fill_mem(24'h0);
    test_reset();
    test_plane_bits();
    test_oe_width();
    test_frame_complete();
    test_reset_mid();
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
